// File: rtl/ysyx_23060203_ifu_fetch.sv
// Instruction fetch stage. It keeps one read in flight on a request/response
// memory port and buffers the returned word for decode. It predicts
// conditional branches statically: backward branches are taken, forward
// branches are not. It takes redirects from a global flush and from a decode
// misprediction.
//
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   flush, flush_pc      global redirect (highest priority) and its target
//   jump_flush, jump_dnpc decode misprediction redirect and its target
//   req_valid/ready/addr fetch request channel (address = current pc)
//   resp_valid/data      in-order read data, one beat per accepted request
//   out_valid/ready      handshake to decode
//   out_pc, out_inst     {pc, instruction} of the buffered word
module ysyx_23060203_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        jump_flush,
  input  logic [31:0] jump_dnpc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int unsigned XLEN = 32;
  localparam logic [4:0]  OP_BRANCH = 5'b11000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic              drop_q, drop_d;

  logic              redir;
  logic [XLEN-1:0]   redir_tgt;
  logic              req_hs;
  logic [XLEN-1:0]   br_imm;
  logic [XLEN-1:0]   npred;

  // Redirect selection; flush wins and the target is kept halfword aligned.
  assign redir     = flush | jump_flush;
  assign redir_tgt = (flush ? flush_pc : jump_dnpc) & ~XLEN'(1);

  assign req_valid = (state_q == S_REQ) & ~reset;
  assign req_addr  = pc_q;
  assign req_hs    = req_valid & req_ready;

  // Gate the output in a redirect cycle so decode never takes a wrong-path word.
  assign out_valid = (state_q == S_HOLD) & ~flush & ~jump_flush;
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;

  // Static prediction: a conditional branch with a negative offset is assumed taken.
  assign br_imm = {{20{inst_q[31]}}, inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign npred  = ((inst_q[6:2] == OP_BRANCH) && inst_q[31]) ? (pc_q + br_imm)
                                                             : (pc_q + XLEN'(4));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    drop_d  = drop_q;
    unique case (state_q)
      S_REQ: begin
        if (redir) begin
          pc_d = redir_tgt;
        end
        if (req_hs) begin
          state_d = S_WAIT;
          // An accepted request to the old pc still returns data; discard it.
          if (redir) begin
            drop_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (redir) begin
          pc_d   = redir_tgt;
          drop_d = 1'b1;
        end
        if (resp_valid) begin
          if (drop_q || redir) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = resp_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redir) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end else if (out_ready) begin
          pc_d    = npred;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060203_ifu_fetch.sv
// Bench for the fetch stage. The main process issues directed vectors and
// queues the expected request addresses and decode transfers. A monitor pops
// and compares them on every handshake. A memory model answers accepted
// requests after a programmable latency.
module tb_ysyx_23060203_ifu_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        jump_flush = 1'b0;
  logic [31:0] jump_dnpc = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  ysyx_23060203_ifu_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .jump_flush (jump_flush),
    .jump_dnpc  (jump_dnpc),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_inst   (out_inst)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_inst[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] br_word = 32'h0000_0013;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: addi x0,x0,imm with imm = word index, except the branch slot.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h3000_0010) return br_word;
    return {addr[13:2], 20'h00013};
  endfunction

  // Memory model: inputs change just after the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      cyc++;
      resp_valid = 1'b0;
      resp_data  = '0;
      if (reset) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        resp_valid = 1'b1;
        resp_data  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
  end

  // Monitor: compares every request and decode handshake against the queues.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        if (req_valid && req_ready) begin
          if (exp_req.size() == 0) chk("unexpected_req", req_addr, 32'hxxxx_xxxx);
          else chk("req_addr", req_addr, exp_req.pop_front());
          pend_addr.push_back(req_addr);
          pend_due.push_back(cyc + lat);
        end
        if (out_valid && out_ready) begin
          if (exp_pc.size() == 0) begin
            chk("unexpected_out", out_pc, 32'hxxxx_xxxx);
          end else begin
            chk("out_pc", out_pc, exp_pc.pop_front());
            chk("out_inst", out_inst, exp_inst.pop_front());
          end
        end
      end
    end
  end

  task automatic push_out(input logic [31:0] pc, input logic [31:0] inst);
    exp_pc.push_back(pc);
    exp_inst.push_back(inst);
  endtask

  // Hold reset for two cycles and return at the falling edge that starts cycle 0.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; flush = 1'b0; jump_flush = 1'b0;
    req_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_req_valid", 32'(req_valid), 32'd0);
      @(negedge clock);
    end
    reset = 1'b0;
  endtask

  // Wait (bounded) until all expected decode transfers have happened.
  task automatic drain(input string name);
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      #3;
      if (exp_pc.size() == 0) break;
    end
    chk({name, "_out_left"}, 32'(exp_pc.size()), 32'd0);
    chk({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
    exp_pc.delete(); exp_inst.delete(); exp_req.delete();
  endtask

  initial begin
    // Sequential fetch with 1-cycle memory.
    lat = 1;
    exp_req.push_back(32'h3000_0000);
    exp_req.push_back(32'h3000_0004);
    exp_req.push_back(32'h3000_0008);
    push_out(32'h3000_0000, 32'h0000_0013);
    push_out(32'h3000_0004, 32'h0010_0013);
    push_out(32'h3000_0008, 32'h0020_0013);
    do_reset();
    #3;
    chk("first_req_valid", 32'(req_valid), 32'd1);
    chk("first_req_addr", req_addr, 32'h3000_0000);
    drain("seq");

    // Backward branch at 0x30000010 is predicted taken.
    br_word = 32'hFE00_0EE3;
    exp_req.push_back(32'h3000_0010);
    exp_req.push_back(32'h3000_000C);
    push_out(32'h3000_0010, 32'hFE00_0EE3);
    push_out(32'h3000_000C, 32'h0030_0013);
    do_reset();
    flush = 1'b1; flush_pc = 32'h3000_0010; req_ready = 1'b0;
    #3;
    chk("req_redir_out_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    flush = 1'b0; req_ready = 1'b1;
    drain("br_back");

    // Forward branch is predicted not taken.
    br_word = 32'h0000_0463;
    exp_req.push_back(32'h3000_0010);
    exp_req.push_back(32'h3000_0014);
    push_out(32'h3000_0010, 32'h0000_0463);
    push_out(32'h3000_0014, 32'h0050_0013);
    do_reset();
    flush = 1'b1; flush_pc = 32'h3000_0010; req_ready = 1'b0;
    @(negedge clock);
    flush = 1'b0; req_ready = 1'b1;
    drain("br_fwd");

    // Decode redirect while waiting: the in-flight response is dropped.
    lat = 3;
    exp_req.push_back(32'h3000_0000);
    exp_req.push_back(32'h3000_0100);
    push_out(32'h3000_0100, 32'h0400_0013);
    do_reset();
    @(negedge clock);
    jump_flush = 1'b1; jump_dnpc = 32'h3000_0101;
    #3;
    chk("wait_out_valid", 32'(out_valid), 32'd0);
    chk("wait_req_valid", 32'(req_valid), 32'd0);
    @(negedge clock);
    jump_flush = 1'b0;
    drain("drop");

    // Flush and jump_flush together in HOLD: flush wins, output gated.
    lat = 1;
    exp_req.push_back(32'h3000_0000);
    exp_req.push_back(32'h3000_0200);
    push_out(32'h3000_0200, 32'h0800_0013);
    do_reset();
    @(negedge clock);
    @(negedge clock);
    flush = 1'b1; flush_pc = 32'h3000_0200;
    jump_flush = 1'b1; jump_dnpc = 32'h3000_0300;
    #3;
    chk("both_out_valid", 32'(out_valid), 32'd0);
    chk("both_req_valid", 32'(req_valid), 32'd0);
    @(negedge clock);
    flush = 1'b0; jump_flush = 1'b0;
    drain("both");

    // Backpressure in HOLD for five cycles.
    exp_req.push_back(32'h3000_0000);
    exp_req.push_back(32'h3000_0004);
    push_out(32'h3000_0000, 32'h0000_0013);
    push_out(32'h3000_0004, 32'h0010_0013);
    do_reset();
    out_ready = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #3;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_pc", out_pc, 32'h3000_0000);
      chk("bp_out_inst", out_inst, 32'h0000_0013);
      chk("bp_req_valid", 32'(req_valid), 32'd0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    drain("bp");

    // Request stalled by req_ready=0 while a redirect moves the address.
    exp_req.push_back(32'h3000_0040);
    push_out(32'h3000_0040, 32'h0100_0013);
    do_reset();
    req_ready = 1'b0;
    #3;
    chk("stall_req_addr0", req_addr, 32'h3000_0000);
    @(negedge clock);
    jump_flush = 1'b1; jump_dnpc = 32'h3000_0040;
    @(negedge clock);
    jump_flush = 1'b0;
    #3;
    chk("stall_req_valid", 32'(req_valid), 32'd1);
    chk("stall_req_addr1", req_addr, 32'h3000_0040);
    @(negedge clock);
    @(negedge clock);
    req_ready = 1'b1;
    drain("stall");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060203_ifu_fetch.md
Name: ysyx_23060203_ifu_fetch

Overview:
Instruction-fetch stage directly upstream of the decode stage. Issues one instruction read at a time on a simple request/response memory port and holds the returned word in a one-entry output buffer. Presents {pc, inst} to decode over a valid/ready handshake. Predicts branches statically (backward taken, forward not-taken; JAL/JALR not predicted) and accepts two redirect sources:
- decode misprediction redirect (jump_flush/jump_dnpc)
- global pipeline flush (exception, mret, fence.i)

Parameters:
RESET_PC, 32'h3000_0000, first fetch address after reset.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
flush  input  1  global flush from back end; highest-priority redirect
flush_pc  input  32  target pc when flush=1
jump_flush  input  1  decode misprediction redirect
jump_dnpc  input  32  target pc when jump_flush=1
req_valid  output  1  fetch request valid
req_ready  input  1  memory accepts request
req_addr  output  32  fetch address; sampled only on req handshake, may change while unaccepted
resp_valid  input  1  read data returned (one per accepted request, in order, >=1 cycle after accept)
resp_data  input  32  instruction word
out_ready  input  1  decode ready
out_valid  output  1  buffered instruction valid
out_pc  output  32  pc of buffered instruction
out_inst  output  32  buffered instruction

Behaviour:
- States: REQ (drive req_valid), WAIT (one request outstanding), HOLD (instruction buffered).
- Reset: state=REQ, pc=RESET_PC, drop=0, inst buffer=0.
- While reset=1, req_valid=0 and out_valid=0. The first request (addr RESET_PC) is driven in the first cycle after reset deasserts.
- req_valid = (state==REQ) & ~reset. req_addr = pc.
- out_valid = (state==HOLD) & ~flush & ~jump_flush. Gating is mandatory so decode never latches a wrong-path word in a redirect cycle.
- out_pc = pc register. out_inst = buffer.
- Redirect: redir = flush | jump_flush. Target = flush ? flush_pc : jump_dnpc (flush wins). Bit 0 of target forced to 0.
- REQ:
  - redir and no handshake: pc <= target, stay REQ.
  - redir with handshake: pc <= target, drop <= 1, go WAIT.
  - handshake only: go WAIT.
- WAIT:
  - redir: pc <= target, drop <= 1 (stays 1 if already set).
  - resp_valid with drop=1 (or redir this cycle): discard data, drop <= 0, go REQ.
  - resp_valid with drop=0 and no redir: buffer <= resp_data, go HOLD.
- HOLD:
  - redir: pc <= target, go REQ. Buffer is discarded, even if out_ready=1.
  - out_valid & out_ready: pc <= npred, go REQ.
  - otherwise hold all state (backpressure, unbounded).
- Prediction, computed from the buffer in HOLD:
  - opcode = inst[6:2].
  - If opcode==5'b11000 and inst[31]=1: npred = pc + {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0}.
  - Else npred = pc + 4.
  - This matches decode's check: a branch with inst[31]=1 is assumed taken; JAL/JALR are always corrected by decode.
- Adders are 32-bit with wrap-around and no overflow flag.
- At most one outstanding request. Throughput is at most 1 instruction per 3 cycles with zero-latency memory; this is accepted.
- Reset mid-WAIT: state returns to REQ with drop=0. The memory port is reset on the same reset, so no stale response is expected.
- resp_valid is ignored outside WAIT.

Test Plan:
- Reset release, memory 1-cycle latency, out_ready=1 → req_addr sequence 0x30000000, 0x30000004, 0x30000008; out_pc matches each; out_valid low during reset.
- Buffer 0xFE000EE3 (beq x0,x0,-4) at pc 0x30000010 → next req_addr 0x3000000C. Buffer 0x00000463 (beq, +8) at 0x30000010 → next 0x30000014.
- jump_flush=1, jump_dnpc=0x30000101 while in WAIT; response arrives 3 cycles later → response discarded, out_valid never rises for it, next req_addr 0x30000100.
- flush=1 (flush_pc 0x30000200) and jump_flush=1 (0x30000300) in the same HOLD cycle with out_ready=1 → out_valid=0 that cycle, next req_addr 0x30000200.
- out_ready=0 for 5 cycles in HOLD → out_valid, out_pc, out_inst stable, req_valid=0; on out_ready=1, one transfer then a request at npred.
- req_ready=0 for 4 cycles with a redirect to 0x30000040 in cycle 2 → req_addr switches to 0x30000040, handshake occurs at that address, no drop.
